dm_lsu: RTL and testbench

DM_LSU -- requirements
Module: dm_lsu

---
 rtl/dm_lsu.sv | 125 ++++++++++++
 tb/tb_dm_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - load/store unit: byte/half/word access to a word-wide synchronous data memory
module dm_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_we,
   input  logic [31:0] mem_dout
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_LCAP, S_LDONE, S_WR, S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic        wr_q;
   logic [1:0]  size_q;
   logic        sext_q;
   logic [11:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        accept;
   logic        misaligned;
   logic [31:0] load_val;
   logic [31:0] merge_din;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign accept     = req && ready;
   assign misaligned = (size == 2'b11) ||
                       (size == 2'b01 && addr[0]) ||
                       (size == 2'b10 && addr[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_LCAP) rdata_q <= load_val;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= wr;
         size_q  <= size;
         sext_q  <= sext;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   // mem_dout holds the addressed word in LCAP (loads) and WR (sub-word stores)
   assign lane_b = mem_dout[{addr_q[1:0], 3'b000} +: 8];
   assign lane_h = mem_dout[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      load_val = mem_dout;
      case (size_q)
         2'b00:   load_val = {{24{sext_q & lane_b[7]}}, lane_b};
         2'b01:   load_val = {{16{sext_q & lane_h[15]}}, lane_h};
         default: load_val = mem_dout;
      endcase
   end

   always_comb begin
      merge_din = mem_dout;
      case (size_q)
         2'b00:   merge_din[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   merge_din[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merge_din = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = rst_n;
            if (accept) begin
               if (misaligned)               state_d = S_ERR;
               else if (wr && size == 2'b10) state_d = S_WR;
               else                          state_d = S_RD;
            end
         end
         S_RD:    state_d = wr_q ? S_WR : S_LCAP;
         S_LCAP:  state_d = S_LDONE;
         S_LDONE: begin
            done    = rst_n;
            state_d = S_IDLE;
         end
         S_WR: begin
            mem_we  = rst_n;
            done    = rst_n;
            state_d = S_IDLE;
         end
         S_ERR: begin
            done    = rst_n;
            err     = rst_n;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_addr = addr_q[11:2];
   assign mem_din  = merge_din;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - scoreboard bench for dm_lsu with a synchronous word memory model
module tb_dm_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic        sext;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic        ready, done, err, mem_we;
   logic [31:0] rdata, mem_din, mem_dout;
   logic [9:0]  mem_addr;

   logic [31:0] mem [0:1023];

   typedef struct {
      string       tag;
      logic        err;
      logic [31:0] rd;
      int          lat;
      logic        we;
      logic [31:0] din;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          we_cnt = 0;
   logic [31:0] model_rd = 32'd0;
   logic        ignore_done = 1'b0;

   dm_lsu dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .wr       (wr),
      .size     (size),
      .sext     (sext),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .done     (done),
      .err      (err),
      .rdata    (rdata),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_we   (mem_we),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && mem_we) we_cnt++;
      if (rst_n && done && !ignore_done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, "_lat"},  32'(cyc - e.acc), 32'(e.lat));
            check({e.tag, "_err"},  32'(err), 32'(e.err));
            check({e.tag, "_rd"},   rdata, e.rd);
            check({e.tag, "_we"},   32'(mem_we), 32'(e.we));
            if (e.we) check({e.tag, "_din"}, mem_din, e.din);
         end
      end
   end

   task automatic access(input string tag, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [11:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int lat,
                         input logic e_we, input logic [31:0] e_din);
      exp_t e;
      int   n;
      n = 0;
      while (!ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(ready), 32'd1);
      if (!w && !e_err) model_rd = e_rd;
      e.tag = tag; e.err = e_err; e.rd = model_rd; e.lat = lat;
      e.we = e_we; e.din = e_din; e.acc = cyc;
      sb_q.push_back(e);
      req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
      @(negedge clk);
      req = 1'b0; wr = $urandom; size = 2'($urandom); sext = $urandom;
      addr = 12'($urandom); wdata = $urandom;
      n = 0;
      while (sb_q.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check({tag, "_timeout"}, 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   initial begin
      int we_before;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[10'h040] = 32'h8899AABB;
      rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
      addr = 12'd0; wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_err",   32'(err), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_we",    32'(mem_we), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      access("lb_102",  1'b0, 2'b00, 1'b1, 12'h102, 32'd0, 1'b0, 32'hFFFFFF99, 3, 1'b0, 32'd0);
      access("lhu_100", 1'b0, 2'b01, 1'b0, 12'h100, 32'd0, 1'b0, 32'h0000AABB, 3, 1'b0, 32'd0);
      access("lw_100",  1'b0, 2'b10, 1'b1, 12'h100, 32'd0, 1'b0, 32'h8899AABB, 3, 1'b0, 32'd0);
      access("lbu_103", 1'b0, 2'b00, 1'b0, 12'h103, 32'd0, 1'b0, 32'h00000088, 3, 1'b0, 32'd0);
      access("lh_102",  1'b0, 2'b01, 1'b1, 12'h102, 32'd0, 1'b0, 32'hFFFF8899, 3, 1'b0, 32'd0);
      access("sb_101",  1'b1, 2'b00, 1'b0, 12'h101, 32'h12345677, 1'b0, 32'd0, 2, 1'b1, 32'h889977BB);
      check("mem_100_after_sb", mem[10'h040], 32'h889977BB);
      access("sw_104",  1'b1, 2'b10, 1'b0, 12'h104, 32'hDEADBEEF, 1'b0, 32'd0, 1, 1'b1, 32'hDEADBEEF);
      check("mem_104_after_sw", mem[10'h041], 32'hDEADBEEF);
      access("lw_104",  1'b0, 2'b10, 1'b0, 12'h104, 32'd0, 1'b0, 32'hDEADBEEF, 3, 1'b0, 32'd0);
      access("lb_101",  1'b0, 2'b00, 1'b1, 12'h101, 32'd0, 1'b0, 32'h00000077, 3, 1'b0, 32'd0);
      access("sh_106",  1'b1, 2'b01, 1'b0, 12'h106, 32'hFFFF1234, 1'b0, 32'd0, 2, 1'b1, 32'h1234BEEF);

      we_before = we_cnt;
      access("lh_103",  1'b0, 2'b01, 1'b1, 12'h103, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0);
      access("sz11",    1'b1, 2'b11, 1'b0, 12'h100, 32'h0BADF00D, 1'b1, 32'd0, 1, 1'b0, 32'd0);
      access("sw_102",  1'b1, 2'b10, 1'b0, 12'h102, 32'h0BADF00D, 1'b1, 32'd0, 1, 1'b0, 32'd0);
      check("err_no_we", 32'(we_cnt - we_before), 32'd0);
      check("mem_100_after_err", mem[10'h040], 32'h889977BB);

      // sh aborted by reset in its WR cycle
      ignore_done = 1'b1;
      req = 1'b1; wr = 1'b1; size = 2'b01; sext = 1'b0; addr = 12'h102; wdata = 32'h00005555;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_done",  32'(done), 32'd0);
      check("abort_we",    32'(mem_we), 32'd0);
      check("abort_ready", 32'(ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ignore_done = 1'b0;
      model_rd = 32'd0;
      #1;
      check("abort_mem",   mem[10'h040], 32'h889977BB);
      check("abort_ready_after", 32'(ready), 32'd1);
      check("abort_rdata", rdata, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end

      access("lw_after_rst", 1'b0, 2'b10, 1'b0, 12'h100, 32'd0, 1'b0, 32'h889977BB, 3, 1'b0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
